// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl
//   Instruction dispatch controller sitting between fetch and the functional
//   units (EU/BIU/FCU by default). One instruction is taken per valid/ready
//   handshake and classified by the number of leading ones in its opcode
//   field. The class selects a target unit and a sub-operation code. The
//   controller then waits for that unit's done, with illegal-opcode and
//   timeout traps, a synchronous flush and a wrapping retire counter.
//
// Ports
//   i_clk           clock, all state on rising edge
//   i_rst           asynchronous active-high reset
//   i_instr_valid   fetch presents i_ir
//   o_instr_ready   controller can accept i_ir
//   i_ir            instruction word
//   i_flush         abort the in-flight instruction (DECODE/ISSUE/WAIT only)
//   i_unit_done     per-unit completion, sampled only in WAIT
//   o_unit_cs       one-hot chip select to the target unit
//   o_unit_sel      sub-operation select to the target unit
//   o_busy          high in every state except IDLE
//   o_retire        one-cycle pulse per completed instruction
//   o_retire_cls    class of the retired instruction, valid with o_retire
//   o_retire_cnt    retired-instruction count, wraps to 0
//   o_trap_valid    trap pending, held until i_trap_ack
//   o_trap_cause    01 illegal opcode, 10 timeout, 00 none
//   i_trap_ack      clears a pending trap
//
// States
//   S_IDLE   | waiting for an instruction from fetch
//   S_DECODE | classify captured opcode, check legality
//   S_ISSUE  | raise chip select and sub-op, clear timer
//   S_WAIT   | hold cs/sel until target done, flush or timeout
//   S_TRAP   | trap reported, waiting for acknowledge

module dispatch_ctrl #(
    parameter int                IR_W      = 32,
    parameter int                OPC_MSB   = 21,
    parameter int                NCLS      = 6,
    parameter int                NUM_UNITS = 3,
    parameter logic [2*NCLS-1:0] UNIT_MAP  = 12'h094,
    parameter logic [2*NCLS-1:0] SEL_MAP   = 12'h910,
    parameter int                TIMEOUT   = 64,
    parameter int                TMO_W     = 8,
    parameter int                CNT_W     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_instr_valid,
    output logic                 o_instr_ready,
    input  logic [IR_W-1:0]      i_ir,
    input  logic                 i_flush,
    input  logic [NUM_UNITS-1:0] i_unit_done,
    output logic [NUM_UNITS-1:0] o_unit_cs,
    output logic [1:0]           o_unit_sel,
    output logic                 o_busy,
    output logic                 o_retire,
    output logic [2:0]           o_retire_cls,
    output logic [CNT_W-1:0]     o_retire_cnt,
    output logic                 o_trap_valid,
    output logic [1:0]           o_trap_cause,
    input  logic                 i_trap_ack
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_ISSUE  = 3'd2,
        S_WAIT   = 3'd3,
        S_TRAP   = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [NCLS-1:0]      r_opc;
    logic [2:0]           r_cls;
    logic [NUM_UNITS-1:0] r_unit_oh;
    logic [1:0]           r_sel;
    logic [1:0]           r_cause_pend;
    logic [TMO_W-1:0]     r_timer;
    logic                 r_ret_pend;

    logic                 r_instr_ready;
    logic [NUM_UNITS-1:0] r_unit_cs;
    logic [1:0]           r_unit_sel;
    logic                 r_busy;
    logic                 r_retire;
    logic [2:0]           r_retire_cls;
    logic [CNT_W-1:0]     r_retire_cnt;
    logic                 r_trap_valid;
    logic [1:0]           r_trap_cause;

    logic [2:0]           w_cls;
    logic [1:0]           w_unit;
    logic [1:0]           w_sel;
    logic                 w_illegal;
    logic [NUM_UNITS-1:0] w_unit_oh;
    logic                 w_tgt_done;
    logic                 w_tmo;

    logic                 w_cap;
    logic                 w_lat;
    logic [NUM_UNITS-1:0] w_cs_nxt;
    logic [1:0]           w_sel_nxt;
    logic [TMO_W-1:0]     w_timer_nxt;
    logic                 w_ret_pend_nxt;
    logic [1:0]           w_cause_pend_nxt;
    logic                 w_trap_valid_nxt;
    logic [1:0]           w_trap_cause_nxt;

    // Only the opcode field is decoded; the rest of the word is not needed.
    logic                 w_ir_unused;
    assign w_ir_unused = ^i_ir;

    // Leading-ones count, MSB first; a field of all ones yields NCLS (illegal).
    always_comb begin
        logic v_stop;
        v_stop = 1'b0;
        w_cls  = '0;
        for (int i = NCLS - 1; i >= 0; i--) begin
            if (!v_stop) begin
                if (r_opc[i]) begin
                    w_cls = w_cls + 3'd1;
                end else begin
                    v_stop = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_unit = '0;
        w_sel  = '0;
        for (int c = 0; c < NCLS; c++) begin
            if (w_cls == 3'(c)) begin
                w_unit = UNIT_MAP[2*c +: 2];
                w_sel  = SEL_MAP[2*c +: 2];
            end
        end
    end

    assign w_illegal  = (w_cls == 3'(NCLS)) || (int'(w_unit) >= NUM_UNITS);
    assign w_unit_oh  = NUM_UNITS'(1) << w_unit;
    assign w_tgt_done = |(i_unit_done & r_unit_oh);
    assign w_tmo      = (TIMEOUT != 0) && (r_timer == TMO_W'(TIMEOUT - 1));

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Priority inside WAIT: flush, then target done, then timeout.
    always_comb begin
        w_state_nxt      = r_state;
        w_cap            = 1'b0;
        w_lat            = 1'b0;
        w_cs_nxt         = r_unit_cs;
        w_sel_nxt        = r_unit_sel;
        w_timer_nxt      = r_timer;
        w_ret_pend_nxt   = 1'b0;
        w_cause_pend_nxt = r_cause_pend;
        w_trap_valid_nxt = r_trap_valid;
        w_trap_cause_nxt = r_trap_cause;
        case (r_state)
            S_IDLE: begin
                if (i_instr_valid) begin
                    w_cap       = 1'b1;
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (i_flush) begin
                    w_state_nxt = S_IDLE;
                end else if (w_illegal) begin
                    w_cause_pend_nxt = 2'b01;
                    w_state_nxt      = S_TRAP;
                end else begin
                    w_lat       = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (i_flush) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cs_nxt    = r_unit_oh;
                    w_sel_nxt   = r_sel;
                    w_timer_nxt = '0;
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (i_flush) begin
                    w_cs_nxt    = '0;
                    w_state_nxt = S_IDLE;
                end else if (w_tgt_done) begin
                    w_cs_nxt       = '0;
                    w_ret_pend_nxt = 1'b1;
                    w_state_nxt    = S_IDLE;
                end else if (w_tmo) begin
                    w_cs_nxt         = '0;
                    w_cause_pend_nxt = 2'b10;
                    w_state_nxt      = S_TRAP;
                end else begin
                    w_timer_nxt = r_timer + TMO_W'(1);
                end
            end
            S_TRAP: begin
                // Acknowledge only counts once the trap has been made visible.
                if (r_trap_valid && i_trap_ack) begin
                    w_trap_valid_nxt = 1'b0;
                    w_trap_cause_nxt = 2'b00;
                    w_state_nxt      = S_IDLE;
                end else begin
                    w_trap_valid_nxt = 1'b1;
                    w_trap_cause_nxt = r_cause_pend;
                end
            end
            default: begin
                w_cs_nxt    = '0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_opc         <= '0;
            r_cls         <= '0;
            r_unit_oh     <= '0;
            r_sel         <= '0;
            r_cause_pend  <= '0;
            r_timer       <= '0;
            r_ret_pend    <= 1'b0;
            r_instr_ready <= 1'b1;
            r_unit_cs     <= '0;
            r_unit_sel    <= '0;
            r_busy        <= 1'b0;
            r_retire      <= 1'b0;
            r_retire_cls  <= '0;
            r_retire_cnt  <= '0;
            r_trap_valid  <= 1'b0;
            r_trap_cause  <= '0;
        end else begin
            if (w_cap) begin
                r_opc <= i_ir[OPC_MSB -: NCLS];
            end
            if (w_lat) begin
                r_cls     <= w_cls;
                r_unit_oh <= w_unit_oh;
                r_sel     <= w_sel;
            end
            r_cause_pend  <= w_cause_pend_nxt;
            r_timer       <= w_timer_nxt;
            r_instr_ready <= (w_state_nxt == S_IDLE);
            r_busy        <= (w_state_nxt != S_IDLE);
            r_unit_cs     <= w_cs_nxt;
            r_unit_sel    <= w_sel_nxt;
            r_trap_valid  <= w_trap_valid_nxt;
            r_trap_cause  <= w_trap_cause_nxt;
            // Retire is reported the cycle after the return to IDLE.
            r_ret_pend    <= w_ret_pend_nxt;
            r_retire      <= r_ret_pend;
            if (r_ret_pend) begin
                r_retire_cls <= r_cls;
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            end
        end
    end

    assign o_instr_ready = r_instr_ready;
    assign o_unit_cs     = r_unit_cs;
    assign o_unit_sel    = r_unit_sel;
    assign o_busy        = r_busy;
    assign o_retire      = r_retire;
    assign o_retire_cls  = r_retire_cls;
    assign o_retire_cnt  = r_retire_cnt;
    assign o_trap_valid  = r_trap_valid;
    assign o_trap_cause  = r_trap_cause;

endmodule

// File: tb/tb_dispatch_ctrl.sv
module tb_dispatch_ctrl;

    localparam logic [11:0] UMAP = 12'h094;
    localparam logic [11:0] SMAP = 12'h910;
    localparam int          TMO  = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] ir;
    logic        flush;
    logic [2:0]  unit_done;
    logic [2:0]  unit_cs;
    logic [1:0]  unit_sel;
    logic        busy;
    logic        retire;
    logic [2:0]  retire_cls;
    logic [1:0]  retire_cnt;
    logic        trap_valid;
    logic [1:0]  trap_cause;
    logic        trap_ack;

    int n_chk   = 0;
    int n_err   = 0;
    int txn_id  = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    dispatch_ctrl #(
        .TIMEOUT (TMO),
        .CNT_W   (2)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_instr_valid (instr_valid),
        .o_instr_ready (instr_ready),
        .i_ir          (ir),
        .i_flush       (flush),
        .i_unit_done   (unit_done),
        .o_unit_cs     (unit_cs),
        .o_unit_sel    (unit_sel),
        .o_busy        (busy),
        .o_retire      (retire),
        .o_retire_cls  (retire_cls),
        .o_retire_cnt  (retire_cnt),
        .o_trap_valid  (trap_valid),
        .o_trap_cause  (trap_cause),
        .i_trap_ack    (trap_ack)
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s txn=%0d actual=%0h required=%0h", nm, txn_id, act, exp);
        end
    endfunction

    // Reference classification: count leading ones of the 6-bit field.
    function automatic int ref_cls(logic [5:0] f);
        int n;
        n = 0;
        while (n < 6 && f[5-n]) n++;
        return n;
    endfunction

    function automatic int ref_unit(int c);
        return int'(UMAP >> (2*c)) & 3;
    endfunction

    function automatic int ref_sel(int c);
        return int'(SMAP >> (2*c)) & 3;
    endfunction

    task automatic chk_reset_vals(string tag);
        chk({tag, "_ready"}, instr_ready, 1);
        chk({tag, "_cs"}, unit_cs, 0);
        chk({tag, "_sel"}, unit_sel, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_retire"}, retire, 0);
        chk({tag, "_rcls"}, retire_cls, 0);
        chk({tag, "_rcnt"}, retire_cnt, 0);
        chk({tag, "_trap"}, trap_valid, 0);
        chk({tag, "_cause"}, trap_cause, 0);
    endtask

    task automatic do_ack(input logic [1:0] cause);
        int hold;
        hold = $urandom_range(0, 2);
        for (int i = 0; i < hold; i++) begin
            flush = 1'($urandom);
            @(negedge clk);
            flush = 1'b0;
            chk("trap_held", trap_valid, 1);
            chk("cause_held", trap_cause, cause);
        end
        trap_ack = 1'b1;
        @(negedge clk);
        trap_ack = 1'b0;
        chk("ack_trap_clr", trap_valid, 0);
        chk("ack_cause_clr", trap_cause, 0);
        chk("ack_ready", instr_ready, 1);
        chk("ack_busy", busy, 0);
    endtask

    // Called at a negedge with the controller in IDLE; returns likewise.
    // done_k/flush_k: WAIT cycle index (0..7) of the event; -2 = flush in
    // DECODE, -1 = flush in ISSUE; anything >= 8 means never.
    task automatic run_txn(input logic [5:0] fld, input int done_k, input int flush_k,
                           input bit noise, input logic [2:0] e_cs, input logic [1:0] e_sel,
                           input bit e_ill, input logic [2:0] e_cls);
        logic [31:0] w;
        w = $urandom;
        w[21:16] = fld;
        txn_id++;
        ir = w;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        ir = $urandom;
        chk("dec_ready", instr_ready, 0);
        chk("dec_busy", busy, 1);
        if (noise) unit_done = 3'($urandom);
        if (flush_k == -2) flush = 1'b1;
        @(negedge clk);
        unit_done = '0;
        flush = 1'b0;
        if (flush_k == -2) begin
            chk("fdec_ready", instr_ready, 1);
            chk("fdec_busy", busy, 0);
            @(negedge clk);
            chk("fdec_trap", trap_valid, 0);
            chk("fdec_cs", unit_cs, 0);
            chk("fdec_retire", retire, 0);
            return;
        end
        if (e_ill) begin
            chk("ill_cs", unit_cs, 0);
            chk("ill_trap_early", trap_valid, 0);
            @(negedge clk);
            chk("ill_trap", trap_valid, 1);
            chk("ill_cause", trap_cause, 2'b01);
            chk("ill_cs2", unit_cs, 0);
            do_ack(2'b01);
            return;
        end
        chk("issue_cs_early", unit_cs, 0);
        if (noise) unit_done = 3'($urandom);
        if (flush_k == -1) flush = 1'b1;
        @(negedge clk);
        unit_done = '0;
        flush = 1'b0;
        if (flush_k == -1) begin
            chk("fiss_cs", unit_cs, 0);
            chk("fiss_ready", instr_ready, 1);
            @(negedge clk);
            chk("fiss_retire", retire, 0);
            chk("fiss_trap", trap_valid, 0);
            return;
        end
        chk("cs", unit_cs, e_cs);
        chk("sel", unit_sel, e_sel);
        for (int k = 0; k < TMO; k++) begin
            unit_done = noise ? (3'($urandom) & ~e_cs) : 3'b000;
            if (k == done_k) unit_done = unit_done | e_cs;
            if (k == flush_k) flush = 1'b1;
            @(negedge clk);
            unit_done = '0;
            flush = 1'b0;
            if (k == flush_k) begin
                chk("flush_cs", unit_cs, 0);
                chk("flush_ready", instr_ready, 1);
                @(negedge clk);
                chk("flush_retire", retire, 0);
                chk("flush_cnt", retire_cnt, exp_cnt);
                chk("flush_trap", trap_valid, 0);
                return;
            end
            if (k == done_k) begin
                chk("done_cs", unit_cs, 0);
                chk("done_ready", instr_ready, 1);
                chk("done_retire_early", retire, 0);
                exp_cnt = (exp_cnt + 1) % 4;
                @(negedge clk);
                chk("retire", retire, 1);
                chk("retire_cls", retire_cls, e_cls);
                chk("retire_cnt", retire_cnt, exp_cnt);
                @(negedge clk);
                chk("retire_pulse", retire, 0);
                return;
            end
            if (k == TMO - 1) begin
                chk("tmo_cs", unit_cs, 0);
                chk("tmo_trap_early", trap_valid, 0);
                @(negedge clk);
                chk("tmo_trap", trap_valid, 1);
                chk("tmo_cause", trap_cause, 2'b10);
                chk("tmo_retire", retire, 0);
                do_ack(2'b10);
                return;
            end
            chk("wait_cs", unit_cs, e_cs);
            chk("wait_sel", unit_sel, e_sel);
            chk("wait_busy", busy, 1);
        end
    endtask

    typedef struct {
        logic [5:0] fld;
        int         done_k;
        int         flush_k;
        bit         noise;
        logic [2:0] e_cs;
        logic [1:0] e_sel;
        bit         e_ill;
        logic [2:0] e_cls;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "bench timed out");
    end

    initial begin
        vecs[0]  = '{6'b000000, 1,  99, 1'b0, 3'b001, 2'b00, 1'b0, 3'd0};
        vecs[1]  = '{6'b111110, 0,  99, 1'b1, 3'b001, 2'b10, 1'b0, 3'd5};
        vecs[2]  = '{6'b110101, 2,  99, 1'b1, 3'b010, 2'b01, 1'b0, 3'd2};
        vecs[3]  = '{6'b111001, 3,  99, 1'b0, 3'b100, 2'b00, 1'b0, 3'd3};
        vecs[4]  = '{6'b100110, 0,  99, 1'b0, 3'b010, 2'b00, 1'b0, 3'd1};
        vecs[5]  = '{6'b111101, 4,  99, 1'b1, 3'b001, 2'b01, 1'b0, 3'd4};
        vecs[6]  = '{6'b111111, 0,  99, 1'b0, 3'b000, 2'b00, 1'b1, 3'd6};
        vecs[7]  = '{6'b011111, 99, 99, 1'b1, 3'b001, 2'b00, 1'b0, 3'd0};
        vecs[8]  = '{6'b000111, 2,  2,  1'b0, 3'b001, 2'b00, 1'b0, 3'd0};
        vecs[9]  = '{6'b110000, 99, -2, 1'b0, 3'b010, 2'b01, 1'b0, 3'd2};
        vecs[10] = '{6'b111111, 99, -2, 1'b0, 3'b000, 2'b00, 1'b1, 3'd6};
        vecs[11] = '{6'b111011, 99, -1, 1'b1, 3'b100, 2'b00, 1'b0, 3'd3};
        vecs[12] = '{6'b111000, 7,  99, 1'b1, 3'b100, 2'b00, 1'b0, 3'd3};

        rst = 1'b1;
        instr_valid = 1'b0;
        ir = '0;
        flush = 1'b0;
        unit_done = '0;
        trap_ack = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_reset_vals("rst");
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("idle");

        for (int i = 0; i < 13; i++) begin
            run_txn(vecs[i].fld, vecs[i].done_k, vecs[i].flush_k, vecs[i].noise,
                    vecs[i].e_cs, vecs[i].e_sel, vecs[i].e_ill, vecs[i].e_cls);
        end

        for (int n = 0; n < 40; n++) begin
            int c, u, r, dk, fk;
            logic [5:0] f;
            c = $urandom_range(0, 6);
            f = 6'($urandom);
            for (int b = 0; b < c; b++) f[5-b] = 1'b1;
            if (c < 6) f[5-c] = 1'b0;
            c = ref_cls(f);
            u = ref_unit(c);
            dk = $urandom_range(0, 9);
            r = $urandom_range(0, 9);
            fk = (r == 0) ? -2 : (r == 1) ? -1 : (r == 2) ? int'($urandom_range(0, 7)) : 99;
            run_txn(f, dk, fk, 1'($urandom), 3'(1 << u), 2'(ref_sel(c)),
                    (c == 6) || (u >= 3), 3'(c));
        end

        // Reset while an instruction sits in WAIT.
        txn_id++;
        ir = 32'h0000_0000;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mid_cs", unit_cs, 3'b001);
        #2;
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        exp_cnt = 0;
        @(negedge clk);

        // Four retires in a row walk the 2-bit counter through 1,2,3,0.
        for (int i = 0; i < 4; i++) begin
            run_txn(6'b000000, 0, 99, 1'b0, 3'b001, 2'b00, 1'b0, 3'd0);
        end
        chk("cnt_wrapped", retire_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
